// File: rtl/bufram32_ctrl_if.sv
// ---------------------------------------------------------------------------
// bufram32_ctrl_if -- signal bundle between a sample source and the
// double-buffer RAM controller.
//
// Signals
//   ED        source -> ctrl  global enable (clock qualifier)
//   START     source -> ctrl  first sample of an input frame (ED-qualified)
//   WE        ctrl -> source  buffer write enable
//   ODD       ctrl -> source  bank select (write half when 1, read half when 0)
//   ADDRW     ctrl -> source  write address, bit 5 always 0
//   ADDRR     ctrl -> source  read address, bit 5 always 0
//   RDY       ctrl -> source  pulse with the first valid output datum of a frame
//   BUSY      ctrl -> source  frame being written or read
//   FERR      ctrl -> source  pulse on frame abort
//   state_dbg ctrl -> source  controller FSM state, for observation only
//
// Qualification rule: there is no valid/ready back-pressure. A sample is
// accepted on every rising clock edge where ED=1 and WE=1; START is only
// looked at when ED=1. With ED=0 nothing in the controller advances.
// ---------------------------------------------------------------------------
interface bufram32_ctrl_if;
    logic       ED;
    logic       START;
    logic       WE;
    logic       ODD;
    logic [5:0] ADDRW;
    logic [5:0] ADDRR;
    logic       RDY;
    logic       BUSY;
    logic       FERR;
    logic [1:0] state_dbg;

    modport master (
        output ED, START,
        input  WE, ODD, ADDRW, ADDRR, RDY, BUSY, FERR, state_dbg
    );

    modport slave (
        input  ED, START,
        output WE, ODD, ADDRW, ADDRR, RDY, BUSY, FERR, state_dbg
    );
endinterface

// File: rtl/bufram32_ctrl.sv
// ---------------------------------------------------------------------------
// bufram32_ctrl -- address/bank controller for a ping-pong frame buffer.
//
// Incoming frames of NPT samples are written in natural order into one half
// of a buffer RAM while the previously completed frame is read out of the
// other half. ODD swaps the halves after the last sample of each frame.
// RDY marks the first datum coming out of the RAM, LAT ED-cycles after the
// first read address of a pass is presented.
//
// Parameters
//   NPT  samples per frame (power of two, 2..32)
//   LAT  buffer-RAM read latency in ED-qualified cycles (>= 1)
//
// Ports
//   CLK  clock, all state changes on its rising edge
//   RST  asynchronous active-high reset
//   bus  bufram32_ctrl_if.slave: ED, START in; WE, ODD, ADDRW, ADDRR, RDY,
//        BUSY, FERR, state_dbg out
//
// Build option
//   BUFRAM32_BITREV_EN  when defined, the read pass visits addresses in
//                       bit-reversed order over log2(NPT) bits; otherwise
//                       natural order. Write order is always natural.
// ---------------------------------------------------------------------------
module bufram32_ctrl #(
    parameter int NPT = 32,
    parameter int LAT = 2
) (
    input  logic            CLK,
    input  logic            RST,
    bufram32_ctrl_if.slave  bus
);

    localparam int AW = (NPT > 1) ? $clog2(NPT) : 1;
    localparam logic [AW-1:0] CNT_LAST = AW'(NPT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wc_q, wc_d;
    logic [AW-1:0]   rc_q, rc_d;
    logic            odd_q, odd_d;
    logic            reading_q, reading_d;
    logic [5:0]      addrr_q, addrr_d;
    logic            first_q, first_d;
    logic [LAT-1:0]  dl_q, dl_d;
    logic            ferr_q, ferr_d;

    logic            we;
    logic            abort;
    logic            last_write;
    logic            last_read;
    logic            pipe_empty;

    // Read-address order for one pass.
    function automatic logic [AW-1:0] perm(input logic [AW-1:0] a);
`ifdef BUFRAM32_BITREV_EN
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
`else
        return a;
`endif
    endfunction

    always_comb begin
        // A frame is being written whenever wc has left 0; START opens one.
        we         = ~RST & bus.ED & (bus.START | (wc_q != '0));
        abort      = bus.ED & bus.START & (wc_q != '0);
        last_write = we & ~bus.START & (wc_q == CNT_LAST);
        last_read  = bus.ED & reading_q & (rc_q == CNT_LAST);
        pipe_empty = ~first_q & (dl_q == '0);

        wc_d      = wc_q;
        rc_d      = rc_q;
        odd_d     = odd_q;
        reading_d = reading_q;
        addrr_d   = addrr_q;
        first_d   = first_q;
        dl_d      = dl_q;
        ferr_d    = abort;
        state_d   = state_q;

        // An aborting START reuses this cycle as sample 0 of the new frame.
        if (we) begin
            wc_d = bus.START ? AW'(1) : wc_q + AW'(1);
        end

        if (bus.ED) begin
            // first_q flags the cycle in which ADDRR holds the first address
            // of a pass; the delay line carries it LAT ED-cycles further.
            first_d = reading_q & (rc_q == '0);
            dl_d[0] = first_q;
            for (int i = 1; i < LAT; i++) begin
                dl_d[i] = dl_q[i-1];
            end
            if (reading_q) begin
                addrr_d = 6'(perm(rc_q));
                rc_d    = rc_q + AW'(1);
                if (rc_q == CNT_LAST) begin
                    reading_d = 1'b0;
                end
            end
        end

        // Swap overrides the end of the previous pass so a new pass can
        // follow the old one with no gap cycle.
        if (last_write) begin
            odd_d     = ~odd_q;
            rc_d      = '0;
            reading_d = 1'b1;
        end

        if (bus.ED) begin
            case (state_q)
                IDLE: begin
                    if (bus.START) begin
                        state_d = reading_q ? RUN : FILL;
                    end
                end
                FILL: begin
                    if (last_write) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (last_read && !last_write && (wc_q == '0) && !bus.START) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.START) begin
                        state_d = reading_q ? RUN : FILL;
                    end else if (pipe_empty) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            wc_q      <= '0;
            rc_q      <= '0;
            odd_q     <= 1'b0;
            reading_q <= 1'b0;
            addrr_q   <= '0;
            first_q   <= 1'b0;
            dl_q      <= '0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wc_q      <= wc_d;
            rc_q      <= rc_d;
            odd_q     <= odd_d;
            reading_q <= reading_d;
            addrr_q   <= addrr_d;
            first_q   <= first_d;
            dl_q      <= dl_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.WE        = we;
    assign bus.ODD       = odd_q;
    assign bus.ADDRW     = bus.START ? 6'd0 : 6'(wc_q);
    assign bus.ADDRR     = addrr_q;
    assign bus.RDY       = dl_q[LAT-1];
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.FERR      = ferr_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_bufram32_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bufram32_ctrl -- directed self-checking bench for bufram32_ctrl.
// Read addresses and RDY are predicted per ED-qualified cycle index when a
// full frame is driven, and compared when that cycle comes around.
// ---------------------------------------------------------------------------
module tb_bufram32_ctrl;
  localparam int NPT = 32;
  localparam int LAT = 2;
  localparam int AW  = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bufram32_ctrl_if bus();

  bufram32_ctrl #(.NPT(NPT), .LAT(LAT)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  int edc = 0;            // index of the current ED=1 cycle
  logic [5:0] exp_q[$];   // expected ADDRR values
  int exp_cyc_q[$];       // ED-cycle index at which each is expected
  int rdy_q[$];           // ED-cycle indices of expected RDY pulses
  int rdy_seen = 0;
  int rdy_pushed = 0;
  logic exp_odd = 1'b0;
  logic exp_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_perm(input int k);
`ifdef BUFRAM32_BITREV_EN
    int r;
    int v;
    r = 0;
    v = k;
    for (int i = 0; i < AW; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return 6'(r);
`else
    return 6'(k);
`endif
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.ED) begin
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= edc) begin
        if (exp_cyc_q[0] == edc) check("addrr", 32'(bus.ADDRR), 32'(exp_q[0]));
        else check("addrr_missed", exp_cyc_q[0], edc);
        void'(exp_cyc_q.pop_front());
        void'(exp_q.pop_front());
      end
      exp_rdy = (rdy_q.size() > 0) && (rdy_q[0] == edc);
      if (bus.RDY || exp_rdy) check("rdy", 32'(bus.RDY), 32'(exp_rdy));
      if (bus.RDY) rdy_seen++;
      if (exp_rdy) void'(rdy_q.pop_front());
      edc++;
    end
  end

  // ---------------- driver tasks ----------------
  // One clock cycle with the given inputs; WE (and ADDRW when writing) are
  // compared mid-cycle. Returns 1 time unit after the closing edge.
  task automatic cyc(input logic ed, input logic start, input logic exp_we, input logic [5:0] exp_addrw);
    bus.ED = ed;
    bus.START = start;
    @(negedge clk);
    check("we", 32'(bus.WE), 32'(exp_we));
    if (exp_we) check("addrw", 32'(bus.ADDRW), 32'(exp_addrw));
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input bit tog, input logic exp_ferr);
    int s;
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        s = edc;
        if (n == NPT) begin
          for (int j = 0; j < NPT; j++) begin
            exp_q.push_back(exp_perm(j));
            exp_cyc_q.push_back(s + NPT + 1 + j);
          end
          rdy_q.push_back(s + NPT + 1 + LAT);
          rdy_pushed++;
        end
      end
      if (k == n - 1) check("odd_before_last", 32'(bus.ODD), 32'(exp_odd));
      cyc(1'b1, k == 0, 1'b1, 6'(k));
      if (k == 0) check("ferr", 32'(bus.FERR), 32'(exp_ferr));
      if (tog) cyc(1'b0, 1'b0, 1'b0, 6'd0);
    end
    if (n == NPT) exp_odd = ~exp_odd;
    check("odd_after", 32'(bus.ODD), 32'(exp_odd));
  endtask

  task automatic idle(input int n, input bit tog);
    for (int i = 0; i < n; i++) cyc(tog ? logic'(i % 2 == 0) : 1'b1, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic drain(input bit tog);
    int guard;
    guard = 0;
    while ((exp_cyc_q.size() > 0 || rdy_q.size() > 0) && guard < 400) begin
      cyc(tog ? logic'(guard % 2 == 0) : 1'b1, 1'b0, 1'b0, 6'd0);
      guard++;
    end
    check("drain_timeout", 32'(guard < 400), 32'd1);
    idle(4, tog);
    check("busy_after_drain", 32'(bus.BUSY), 32'd0);
    check("state_after_drain", 32'(bus.state_dbg), 32'(ST_IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.ED = 1'b1;
    bus.START = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    // reset state, START held high
    check("rst_we", 32'(bus.WE), 32'd0);
    check("rst_odd", 32'(bus.ODD), 32'd0);
    check("rst_addrr", 32'(bus.ADDRR), 32'd0);
    check("rst_addrw", 32'(bus.ADDRW), 32'd0);
    check("rst_rdy", 32'(bus.RDY), 32'd0);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    check("rst_ferr", 32'(bus.FERR), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    rst = 1'b0;
    bus.START = 1'b0;

    // single frame: addresses 0..31, swap after 32nd write, RDY 35 cycles on
    send_frame(NPT, 1'b0, 1'b0);
    check("busy_after_frame", 32'(bus.BUSY), 32'd1);
    check("state_run", 32'(bus.state_dbg), 32'(ST_RUN));
    drain(1'b0);

    // continuous frames
    for (int f = 0; f < 3; f++) begin
      send_frame(NPT, 1'b0, 1'b0);
      check("cont_state_run", 32'(bus.state_dbg), 32'(ST_RUN));
    end
    drain(1'b0);

    // abort: full frame, then a frame restarted at wc=10, then completed
    send_frame(NPT, 1'b0, 1'b0);
    send_frame(10, 1'b0, 1'b0);
    send_frame(NPT, 1'b0, 1'b1);
    check("ferr_cleared", 32'(bus.FERR), 32'd0);
    drain(1'b0);

    // ED toggling 1010... for a whole frame and its readout
    send_frame(NPT, 1'b1, 1'b0);
    drain(1'b1);

    // reset in the middle of a frame at wc=20
    send_frame(20, 1'b0, 1'b0);
    check("pre_rst_busy", 32'(bus.BUSY), 32'd1);
    bus.ED = 1'b1;
    bus.START = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_we", 32'(bus.WE), 32'd0);
    check("mid_rst_odd", 32'(bus.ODD), 32'd0);
    check("mid_rst_addrr", 32'(bus.ADDRR), 32'd0);
    check("mid_rst_addrw", 32'(bus.ADDRW), 32'd0);
    check("mid_rst_rdy", 32'(bus.RDY), 32'd0);
    check("mid_rst_busy", 32'(bus.BUSY), 32'd0);
    check("mid_rst_ferr", 32'(bus.FERR), 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_we_hold", 32'(bus.WE), 32'd0);
    rst = 1'b0;
    bus.START = 1'b0;
    exp_odd = 1'b0;
    idle(50, 1'b0);
    send_frame(NPT, 1'b0, 1'b0);
    drain(1'b0);

    check("rdy_count", rdy_seen, rdy_pushed);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bufram32_ctrl.md
BUFRAM32_CTRL -- requirements
Module: bufram32_ctrl

Interface
REQ-001 The block SHALL have parameter NPT, default 32, meaning complex samples per frame; legal values are powers of two, 2 to 32.
REQ-002 The block SHALL have parameter LAT, default 2, meaning buffer-RAM read latency in ED-qualified cycles.
REQ-003 Port CLK  in  1  is the single clock; all state changes on posedge CLK.
REQ-004 Port RST  in  1  is the reset, asynchronous and active-high.
REQ-005 Port ED  in  1  is the global enable; no state advances when ED=0.
REQ-006 Port START  in  1  marks the first sample of an input frame; it is sampled only when ED=1.
REQ-007 Port WE  out  1  is the buffer write enable.
REQ-008 Port ODD  out  1  is the bank select: the write half is selected when ODD=1, the read half when ODD=0, per buffer convention.
REQ-009 Port ADDRW  out  6  is the write address; bit 5 is always 0.
REQ-010 Port ADDRR  out  6  is the read address; bit 5 is always 0.
REQ-011 Port RDY  out  1  is a one-cycle pulse that coincides with the first valid output datum of a frame.
REQ-012 Port BUSY  out  1  is high while a frame is being written or read.
REQ-013 Port FERR  out  1  is a one-cycle pulse on frame abort.

Function
REQ-014 States SHALL be IDLE, FILL, RUN and DRAIN; the write counter wc and read counter rc are each log2(NPT) bits.
REQ-015 IDLE->FILL SHALL occur on ED&START; sample 0 is written in that same cycle.
REQ-016 WE SHALL be combinational: WE = ED & (START | writing), and ADDRW = START ? 0 : wc.
REQ-017 Each ED&WE cycle SHALL increment wc; when the write with wc=NPT-1 occurs, ODD SHALL toggle on the next edge, rc SHALL reset to 0, and a read pass SHALL begin.
REQ-018 FILL SHALL go to RUN at the first swap; in RUN, writes and reads of the opposite halves SHALL proceed concurrently.
REQ-019 ADDRR SHALL be registered, SHALL advance one per ED cycle during a read pass, and SHALL equal perm(rc).
REQ-020 RDY SHALL pulse exactly LAT ED-cycles after ADDRR presents the first address of a pass; the LAT-deep delay line SHALL be ED-gated.
REQ-021 If the last read (rc=NPT-1) and the last write of the next frame occur in the same cycle, the swap and the new read pass SHALL follow back-to-back with no gap cycle.
REQ-022 START while wc!=0 SHALL abort the write: wc restarts at 0 with the current sample as sample 0, FERR pulses, and ODD does not toggle; any read pass in progress SHALL continue unaffected.
REQ-023 In RUN, if the read pass ends with no frame being written (wc=0 and no START), the state SHALL go to DRAIN; DRAIN SHALL go to IDLE after the RDY delay line empties.
REQ-024 START in DRAIN or IDLE SHALL enter FILL, or RUN if a read pass is still active.
REQ-025 BUSY = (state != IDLE).
REQ-026 Frame-to-first-output latency SHALL be NPT+1+LAT ED-cycles from START.

Reset
REQ-027 While RST=1, the block SHALL be in IDLE with ODD=0, wc=0, rc=0, ADDRR=0, RDY=0, FERR=0, BUSY=0 and the delay line cleared.
REQ-028 While RST=1, WE SHALL be held at 0 regardless of START.
REQ-029 RST asserted mid-frame SHALL discard the frame, and no RDY for that frame SHALL appear after release.

Configuration
REQ-030 Macro BUFRAM32_BITREV_EN SHALL select the read-address order.
REQ-031 With BUFRAM32_BITREV_EN defined, perm(rc) SHALL be the bit-reverse of rc over log2(NPT) bits.
REQ-032 Without BUFRAM32_BITREV_EN, perm(rc) = rc (natural order); write order is unaffected either way.

Verification
REQ-033 Reset, then START with ED=1 and NPT=32 -> ADDRW 0..31 with WE on every cycle, ODD goes 0->1 after the 32nd write, RDY at cycle 35 after START.
REQ-034 BITREV_EN defined, single frame -> ADDRR sequence 0,16,8,24,4,...,31; undefined -> 0,1,2,...,31.
REQ-035 Continuous frames (START every 32 cycles) -> ODD toggles every 32 cycles, ADDRR has no idle gap, RDY every 32 cycles, state stays RUN.
REQ-036 START at wc=10 -> FERR pulse, ADDRW returns to 0, no ODD toggle, the ongoing read pass completes intact.
REQ-037 ED toggled 1010... for a whole frame -> addresses and RDY advance only on ED=1 cycles, and the 2-cycle ED latency is preserved.
REQ-038 RST pulse at wc=20 -> all outputs 0 immediately, no RDY after release, the next START restarts at ADDRW=0 with ODD=0.
